// File: rtl/gpu_pkg.sv
// Shared types and helpers for the GPU sprite pipeline: colour-table types,
// bits-per-pixel and entry-address helpers, and AXI response codes.
package gpu_pkg;

    typedef enum logic [3:0] {
        CT_BIT_8  = 4'd0,
        CT_BIT_4  = 4'd1,
        CT_BIT_2  = 4'd2,
        CT_BIT_1  = 4'd3,
        CT_BIT_16 = 4'd4,
        CT_NONE   = 4'd5
    } ct_type_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Zero bits per pixel marks a type that bypasses the colour table.
    function automatic logic [4:0] ct_bpp(input ct_type_e t);
        logic [4:0] bpp;
        case (t)
            CT_BIT_8:  bpp = 5'd8;
            CT_BIT_4:  bpp = 5'd4;
            CT_BIT_2:  bpp = 5'd2;
            CT_BIT_1:  bpp = 5'd1;
            CT_BIT_16: bpp = 5'd16;
            default:   bpp = 5'd0;
        endcase
        return bpp;
    endfunction

    function automatic logic [31:0] ct_byte_addr(input logic [31:0] base, input logic [15:0] index);
        return base + {15'd0, index, 1'b0};
    endfunction

    // Entries at byte offset 2 within a word live in the low half of the read data.
    function automatic logic [15:0] ct_pick_half(input logic [31:0] word, input logic odd_half);
        return odd_half ? word[15:0] : word[31:16];
    endfunction

endpackage

// File: rtl/gpu_ct_index_extract.sv
// Combinational extraction of the colour-table index for one pixel slot of a
// sprite-sheet halfword; flags types that bypass the colour table.
module gpu_ct_index_extract
    import gpu_pkg::*;
(
    input  logic [15:0] data,
    input  logic [3:0]  ct_type,
    input  logic [3:0]  slot,
    output logic [15:0] index,
    output logic        bypass
);

    logic [4:0]  bpp_s;
    logic [3:0]  slot_mask_s;
    logic [3:0]  slot_m_s;
    logic [4:0]  span_s;
    logic [4:0]  shift_s;
    logic [15:0] field_mask_s;

    // Slot 0 is the most significant field, so shift right by what lies below the field.
    always_comb begin
        bpp_s  = ct_bpp(ct_type_e'(ct_type));
        bypass = (bpp_s == 5'd0);
        case (bpp_s)
            5'd8:    slot_mask_s = 4'd1;
            5'd4:    slot_mask_s = 4'd3;
            5'd2:    slot_mask_s = 4'd7;
            5'd1:    slot_mask_s = 4'd15;
            default: slot_mask_s = 4'd0;
        endcase
        slot_m_s     = slot & slot_mask_s;
        span_s       = bpp_s * ({1'b0, slot_m_s} + 5'd1);
        shift_s      = 5'd16 - span_s;
        field_mask_s = 16'hFFFF >> (5'd16 - bpp_s);
        index        = (data >> shift_s) & field_mask_s;
    end

endmodule

// File: rtl/gpu_ct_resolve.sv
// Sprite pipeline stage 4: resolves colour-table indices to colours over AXI-lite.
// Optional GPU_CT_CACHE_EN adds a one-entry cache of the last colour-table word.
module gpu_ct_resolve
    import gpu_pkg::*;
#(
    parameter logic [15:0] ERR_COLOUR = 16'hF81F,
    parameter int          COORD_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               re_valid,
    output logic               re_ready,
    input  logic [15:0]        re_data,
    input  logic [3:0]         re_ct_type,
    input  logic [3:0]         re_slot,
    input  logic [31:0]        re_ct_base,
    input  logic [COORD_W-1:0] re_screen_x,
    input  logic [COORD_W-1:0] re_screen_y,
    output logic               axi_arvalid,
    input  logic               axi_arready,
    output logic [31:0]        axi_araddr,
    input  logic               axi_rvalid,
    output logic               axi_rready,
    input  logic [31:0]        axi_rdata,
    input  logic [1:0]         axi_rresp,
    output logic [15:0]        se_colour,
    output logic [COORD_W-1:0] se_screen_x,
    output logic [COORD_W-1:0] se_screen_y,
    output logic               se_valid,
    input  logic               se_ready
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SET_ADDRESS = 2'd1,
        ST_GET_DATA    = 2'd2,
        ST_DATA_READY  = 2'd3
    } state_e;

    state_e      state_r;
    logic        odd_half_r;
    logic [15:0] index_s;
    logic        bypass_s;
    logic [31:0] ea_s;
    logic        cache_hit_s;
    logic [31:0] cache_word_s;
    logic        r_hs_s;
    logic        unused_s;

    gpu_ct_index_extract u_index_extract (
        .data    (re_data),
        .ct_type (re_ct_type),
        .slot    (re_slot),
        .index   (index_s),
        .bypass  (bypass_s)
    );

    assign ea_s     = ct_byte_addr(re_ct_base, index_s);
    assign r_hs_s   = (state_r == ST_GET_DATA) && axi_rvalid && axi_rready;
    assign unused_s = ea_s[0];

`ifdef GPU_CT_CACHE_EN
    logic        cache_valid_r;
    logic [29:0] cache_tag_r;
    logic [31:0] cache_data_r;

    // Remember the last good colour-table word; an error response drops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid_r <= 1'b0;
            cache_tag_r   <= 30'd0;
            cache_data_r  <= 32'd0;
        end else if (r_hs_s) begin
            if (axi_rresp == AXI_RESP_OKAY) begin
                cache_valid_r <= 1'b1;
                cache_tag_r   <= axi_araddr[31:2];
                cache_data_r  <= axi_rdata;
            end else begin
                cache_valid_r <= 1'b0;
            end
        end
    end

    assign cache_hit_s  = cache_valid_r && (cache_tag_r == ea_s[31:2]);
    assign cache_word_s = cache_data_r;
`else
    assign cache_hit_s  = 1'b0;
    assign cache_word_s = 32'd0;
`endif

    // Main FSM; every port it drives is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            re_ready    <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_araddr  <= 32'd0;
            axi_rready  <= 1'b0;
            se_valid    <= 1'b0;
            se_colour   <= 16'd0;
            se_screen_x <= '0;
            se_screen_y <= '0;
            odd_half_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!re_ready) begin
                        re_ready <= 1'b1;
                    end else if (re_valid) begin
                        re_ready    <= 1'b0;
                        odd_half_r  <= ea_s[1];
                        se_screen_x <= re_screen_x;
                        se_screen_y <= re_screen_y;
                        if (bypass_s) begin
                            se_colour <= re_data;
                            se_valid  <= 1'b1;
                            state_r   <= ST_DATA_READY;
                        end else if (cache_hit_s) begin
                            se_colour <= ct_pick_half(cache_word_s, ea_s[1]);
                            se_valid  <= 1'b1;
                            state_r   <= ST_DATA_READY;
                        end else begin
                            axi_arvalid <= 1'b1;
                            axi_araddr  <= {ea_s[31:2], 2'b00};
                            state_r     <= ST_SET_ADDRESS;
                        end
                    end
                end
                ST_SET_ADDRESS: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state_r     <= ST_GET_DATA;
                    end
                end
                ST_GET_DATA: begin
                    if (r_hs_s) begin
                        axi_rready <= 1'b0;
                        se_valid   <= 1'b1;
                        se_colour  <= (axi_rresp != AXI_RESP_OKAY) ? ERR_COLOUR
                                      : ct_pick_half(axi_rdata, odd_half_r);
                        state_r    <= ST_DATA_READY;
                    end
                end
                ST_DATA_READY: begin
                    if (se_ready) begin
                        se_valid <= 1'b0;
                        re_ready <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    string dbg_state;

    // Human-readable state name for waveform viewing.
    always_comb begin
        case (state_r)
            ST_IDLE:        dbg_state = "IDLE";
            ST_SET_ADDRESS: dbg_state = "SET_ADDRESS";
            ST_GET_DATA:    dbg_state = "GET_DATA";
            ST_DATA_READY:  dbg_state = "DATA_READY";
            default:        dbg_state = "UNKNOWN";
        endcase
    end
`endif

endmodule
